// File: rtl/frame_copy_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_copy_engine_if
//  Description : Source-read / destination-write bus of the frame copy
//                engine. The master side (the engine) issues reads and
//                writes. The slave side holds the frame buffers.
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_copy_engine_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 16
);
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [DATA_W-1:0] src_rd_data;
    logic              dst_ready;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [DATA_W-1:0] dst_wr_data;

    modport master (
        output src_rd_en,
        output src_rd_addr,
        input  src_rd_data,
        input  dst_ready,
        output dst_wr_en,
        output dst_wr_addr,
        output dst_wr_data
    );

    modport slave (
        input  src_rd_en,
        input  src_rd_addr,
        output src_rd_data,
        output dst_ready,
        input  dst_wr_en,
        input  dst_wr_addr,
        input  dst_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/frame_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : frame_copy_engine
//  Description : Copies one frame from the camera buffer to the VGA buffer
//                while the system controller sits in COPY (3'b100).
//                Reads are credit-limited against a small skid FIFO. The
//                destination sees a registered write stage that holds
//                while dst_ready is low.
//                Optional feature macro: COPY_CHECKSUM_EN (16-bit running
//                sum of the written words; tied to zero when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module frame_copy_engine #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int FRAME_WORDS = 307200,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [2:0]            state,
    frame_copy_engine_if.master        mem,
    output logic                       busy,
    output logic                       copy_finished,
    output logic [15:0]                checksum
);
    localparam logic [2:0]        c_COPY_STATE = 3'b100;
    localparam int                c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                c_CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(FRAME_WORDS - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]         r_fsm;
    logic [1:0]         w_fsm_nxt;
    logic               r_in_copy_d;
    logic               w_in_copy;
    logic               w_start;
    logic               w_abort;
    logic               w_flush;
    logic               w_active;
    logic               w_issue;
    logic               w_credit_ok;
    logic               w_ret;
    logic               w_wr_done;
    logic               w_avail;
    logic               w_load;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;

    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  r_ld_addr;
    logic [RD_LAT-1:0]  r_pipe;
    logic [2:0]         r_inflight;

    logic [DATA_W-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;

    logic               r_wr_vld;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;

    // Entry into COPY is the only start condition; leaving COPY aborts.
    assign w_in_copy    = (state == c_COPY_STATE);
    assign w_start      = w_in_copy && !r_in_copy_d;
    assign w_abort      = ((r_fsm == c_S_RUN) || (r_fsm == c_S_DRAIN)) && !w_in_copy;
    assign w_flush      = w_start || w_abort;
    assign w_active     = ((r_fsm == c_S_RUN) || (r_fsm == c_S_DRAIN)) && w_in_copy;

    // Reads already launched plus words parked in the FIFO may never exceed
    // the FIFO depth, so every returning word always has a slot.
    assign w_credit_ok  = (int'(r_inflight) + int'(r_fifo_cnt)) < FIFO_DEPTH;
    assign w_issue      = (r_fsm == c_S_RUN) && w_in_copy && w_credit_ok;
    assign w_ret        = r_pipe[RD_LAT-1];
    assign w_fifo_empty = (r_fifo_cnt == '0);

    // Output stage reloads on the same edge a write completes; a returning
    // word bypasses an empty FIFO so the first write is not delayed.
    assign w_wr_done    = mem.dst_wr_en && mem.dst_ready;
    assign w_avail      = w_ret || !w_fifo_empty;
    assign w_load       = w_avail && (!r_wr_vld || w_wr_done);
    assign w_pop        = w_load && !w_fifo_empty;
    assign w_push       = w_ret && !(w_load && w_fifo_empty);

    assign mem.src_rd_en   = w_issue;
    assign mem.src_rd_addr = r_rd_addr;
    assign mem.dst_wr_en   = r_wr_vld && w_active;
    assign mem.dst_wr_addr = r_wr_addr;
    assign mem.dst_wr_data = r_wr_data;

    // Control state register and COPY-entry edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= c_S_IDLE;
            r_in_copy_d <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_in_copy_d <= w_in_copy;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_fsm_nxt     = r_fsm;
        busy          = 1'b0;
        copy_finished = 1'b0;
        case (r_fsm)
            c_S_IDLE: begin
                if (w_start) w_fsm_nxt = c_S_RUN;
            end
            c_S_RUN: begin
                busy = 1'b1;
                if (!w_in_copy)                           w_fsm_nxt = c_S_IDLE;
                else if (w_issue && r_rd_addr == c_LAST_ADDR) w_fsm_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                busy = 1'b1;
                if (!w_in_copy)                               w_fsm_nxt = c_S_IDLE;
                else if (w_wr_done && r_wr_addr == c_LAST_ADDR) w_fsm_nxt = c_S_DONE;
            end
            default: begin
                copy_finished = 1'b1;
                if (!w_in_copy) w_fsm_nxt = c_S_IDLE;
            end
        endcase
    end

    // Read address, latency tracker and in-flight count; a flush discards
    // every read still on its way back.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_rd_addr  <= '0;
            r_pipe     <= '0;
            r_inflight <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | RD_LAT'(w_issue);
            if (w_issue) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            if (w_issue && !w_ret)      r_inflight <= r_inflight + 3'd1;
            else if (!w_issue && w_ret) r_inflight <= r_inflight - 3'd1;
        end
    end

    // Skid FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= (r_rptr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
            else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
        end
    end

    // Skid FIFO storage; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wptr] <= mem.src_rd_data;
    end

    // Registered write stage; addresses are assigned in load order, which
    // matches the order reads were issued.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_ld_addr <= '0;
        end else if (w_load) begin
            r_wr_vld  <= 1'b1;
            r_wr_addr <= r_ld_addr;
            r_wr_data <= w_fifo_empty ? mem.src_rd_data : r_fifo_mem[r_rptr];
            r_ld_addr <= r_ld_addr + ADDR_W'(1);
        end else if (w_wr_done) begin
            r_wr_vld  <= 1'b0;
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [15:0] w_word16;
    logic [15:0] r_checksum;

    if (DATA_W >= 16) begin : g_cs_trunc
        assign w_word16 = r_wr_data[15:0];
    end else begin : g_cs_ext
        assign w_word16 = {{(16 - DATA_W){1'b0}}, r_wr_data};
    end

    // Running sum of completed writes, restarted on every COPY entry.
    always_ff @(posedge clk) begin
        if (reset || w_start) r_checksum <= 16'h0000;
        else if (w_wr_done)   r_checksum <= r_checksum + w_word16;
    end

    assign checksum = r_checksum;
`else
    assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_copy_engine
//  Description : Self-checking bench for frame_copy_engine. A 16-word and a
//                1-word instance are driven; writes are logged and compared
//                against the expected frame word[i] = 16'h1000 + i.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_copy_engine;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int FW     = 16;
    localparam int DEPTH  = 4;
    localparam logic [2:0] COPY = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  state = 3'b000;
    logic [2:0]  state1 = 3'b000;
    logic        busy, copy_finished, busy1, fin1;
    logic [15:0] checksum, cs1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_copy_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    frame_copy_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    frame_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FW),
                        .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .state(state), .mem(bus.master),
        .busy(busy), .copy_finished(copy_finished), .checksum(checksum));

    frame_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(1),
                        .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(reset), .state(state1), .mem(bus1.master),
        .busy(busy1), .copy_finished(fin1), .checksum(cs1));

    // Source frame buffers: two-cycle read latency, word[i] = 16'h1000 + i.
    logic [15:0] m_d1 = 16'hDEAD, m_d2 = 16'hDEAD, m1_d1 = 16'hDEAD, m1_d2 = 16'hDEAD;
    always @(posedge clk) begin
        m_d1  <= bus.src_rd_en  ? 16'h1000 + bus.src_rd_addr[15:0]  : 16'hDEAD;
        m_d2  <= m_d1;
        m1_d1 <= bus1.src_rd_en ? 16'h1000 + bus1.src_rd_addr[15:0] : 16'hDEAD;
        m1_d2 <= m1_d1;
    end
    assign bus.src_rd_data  = m_d2;
    assign bus1.src_rd_data = m1_d2;

    function automatic logic [15:0] word_of(input int i);
        return 16'(32'h1000 + i);
    endfunction

    function automatic logic [15:0] exp_cs(input int n);
        logic [15:0] s = 16'h0000;
`ifdef COPY_CHECKSUM_EN
        for (int i = 0; i < n; i++) s = s + word_of(i);
`endif
        return s;
    endfunction

    // Write log and bus observations, sampled mid-cycle.
    int          wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          wr1_addr_q[$];
    logic [15:0] wr1_data_q[$];
    int          n_rd = 0, n_wr = 0, stab_err = 0, max_occ = 0;
    logic        prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        int occ;
        occ = n_rd - n_wr - (bus.dst_wr_en ? 1 : 0);
        if (occ > max_occ) max_occ = occ;
        if (prev_stall && !(bus.dst_wr_en && bus.dst_wr_addr == prev_addr && bus.dst_wr_data == prev_data))
            stab_err++;
        prev_stall = bus.dst_wr_en && !bus.dst_ready;
        prev_addr  = bus.dst_wr_addr;
        prev_data  = bus.dst_wr_data;
        if (bus.src_rd_en) n_rd++;
        if (bus.dst_wr_en && bus.dst_ready) begin
            wr_addr_q.push_back(int'(bus.dst_wr_addr));
            wr_data_q.push_back(bus.dst_wr_data);
            wr_cyc_q.push_back(cyc);
            n_wr++;
        end
        if (bus1.dst_wr_en && bus1.dst_ready) begin
            wr1_addr_q.push_back(int'(bus1.dst_wr_addr));
            wr1_data_q.push_back(bus1.dst_wr_data);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        n_rd = 0; n_wr = 0; stab_err = 0; max_occ = 0; prev_stall = 1'b0;
    endtask

    // Drives dst_ready per pattern until copy_finished or the cycle budget.
    task automatic run_until_done(input int mode, input int limit, output int fin_cyc, output bit ok);
        ok = 1'b0; fin_cyc = -1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (copy_finished) begin ok = 1'b1; fin_cyc = cyc; break; end
            case (mode)
                0:       bus.dst_ready = 1'b1;
                1:       bus.dst_ready = (k >= 12 && k < 22) ? 1'b0 : (k % 2 == 0);
                default: bus.dst_ready = ($urandom_range(0, 99) < 55);
            endcase
        end
        bus.dst_ready = 1'b1;
    endtask

    task automatic begin_copy(output int start_cyc);
        state = 3'b000;
        repeat (2) @(posedge clk);
        #1; clear_log(); state = COPY; start_cyc = cyc;
    endtask

    task automatic test_reset();
        int fc; bit ok;
        reset = 1'b1; state = COPY; bus.dst_ready = 1'b1; bus1.dst_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.src_rd_en, bus.dst_wr_en, busy, copy_finished, checksum, bus.dst_wr_addr, bus.dst_wr_data} !== '0)
                $display("FAIL reset_outputs: rd_en=%b wr_en=%b busy=%b fin=%b cs=%h waddr=%h wdata=%h, required all 0",
                         bus.src_rd_en, bus.dst_wr_en, busy, copy_finished, checksum, bus.dst_wr_addr, bus.dst_wr_data);
            else n_pass++;
        end
        n_checks++;
        if (n_rd !== 0) $display("FAIL reset_no_reads: reads=%0d required 0", n_rd); else n_pass++;
        clear_log();
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, bus.src_rd_en} !== 2'b11 || bus.src_rd_addr !== '0)
            $display("FAIL reset_release_start: busy=%b rd_en=%b raddr=%0d required 1 1 0", busy, bus.src_rd_en, bus.src_rd_addr);
        else n_pass++;
        run_until_done(0, 200, fc, ok);
        n_checks++;
        if (ok !== 1'b1 || n_wr !== FW) $display("FAIL reset_first_copy: done=%b writes=%0d required 1 %0d", ok, n_wr, FW);
        else n_pass++;
    endtask

    task automatic test_free_flow();
        int s, fc; bit ok;
        bus.dst_ready = 1'b1;
        begin_copy(s);
        run_until_done(0, 200, fc, ok);
        n_checks++;
        if (!ok || wr_addr_q.size() != FW) $display("FAIL free_count: done=%b writes=%0d required 1 %0d", ok, wr_addr_q.size(), FW);
        else n_pass++;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== word_of(i))
                $display("FAIL free_word[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wr_addr_q[i], wr_data_q[i], i, word_of(i));
            else n_pass++;
        end
        if (wr_cyc_q.size() == FW) begin
            n_checks++;
            if (wr_cyc_q[0] - s !== 4) $display("FAIL free_first_latency: %0d cycles required 4", wr_cyc_q[0] - s); else n_pass++;
            n_checks++;
            if (wr_cyc_q[FW-1] - wr_cyc_q[0] !== FW - 1)
                $display("FAIL free_rate: span=%0d required %0d", wr_cyc_q[FW-1] - wr_cyc_q[0], FW - 1);
            else n_pass++;
            n_checks++;
            if (fc !== wr_cyc_q[FW-1] + 1) $display("FAIL free_finish_cycle: %0d required %0d", fc, wr_cyc_q[FW-1] + 1); else n_pass++;
        end
        n_checks++;
        if (checksum !== exp_cs(FW)) $display("FAIL free_checksum: %h required %h", checksum, exp_cs(FW)); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (copy_finished !== 1'b1 || busy !== 1'b0) $display("FAIL free_finish_hold: fin=%b busy=%b required 1 0", copy_finished, busy);
        else n_pass++;
        state = 3'b000;
        @(posedge clk); #1;
        n_checks++;
        if (copy_finished !== 1'b0) $display("FAIL free_finish_drop: fin=%b required 0", copy_finished); else n_pass++;
    endtask

    task automatic test_copy_under_ready(input string name, input int mode);
        int s, fc; bit ok;
        begin_copy(s);
        run_until_done(mode, 600, fc, ok);
        n_checks++;
        if (!ok || wr_addr_q.size() != FW) $display("FAIL %s_count: done=%b writes=%0d required 1 %0d", name, ok, wr_addr_q.size(), FW);
        else n_pass++;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== word_of(i))
                $display("FAIL %s_word[%0d]: addr=%0d data=%h required addr=%0d data=%h", name, i, wr_addr_q[i], wr_data_q[i], i, word_of(i));
            else n_pass++;
        end
        n_checks++;
        if (stab_err !== 0) $display("FAIL %s_stall_stable: %0d unstable stalls required 0", name, stab_err); else n_pass++;
        n_checks++;
        if (max_occ > DEPTH) $display("FAIL %s_credit: occupancy %0d required <= %0d", name, max_occ, DEPTH); else n_pass++;
        n_checks++;
        if (checksum !== exp_cs(FW)) $display("FAIL %s_checksum: %h required %h", name, checksum, exp_cs(FW)); else n_pass++;
    endtask

    task automatic test_backpressure();
        test_copy_under_ready("backpressure", 1);
    endtask

    task automatic test_random_ready();
        for (int r = 0; r < 3; r++) test_copy_under_ready("random", 2);
    endtask

    task automatic test_abort();
        int s, rd0, fc; bit ok, fin_seen;
        bus.dst_ready = 1'b1;
        begin_copy(s);
        for (int k = 0; k < 100 && n_wr < 5; k++) begin @(posedge clk); #1; end
        state = 3'b000;
        #1;
        n_checks++;
        if ({bus.src_rd_en, bus.dst_wr_en} !== 2'b00)
            $display("FAIL abort_immediate: rd_en=%b wr_en=%b required 0 0", bus.src_rd_en, bus.dst_wr_en);
        else n_pass++;
        rd0 = n_rd;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_idle: busy=%b required 0", busy); else n_pass++;
        fin_seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (copy_finished) fin_seen = 1'b1; end
        n_checks++;
        if (n_rd !== rd0 || n_wr !== 5 || fin_seen)
            $display("FAIL abort_quiet: reads=%0d writes=%0d fin=%b required %0d 5 0", n_rd, n_wr, fin_seen, rd0);
        else n_pass++;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== i) $display("FAIL abort_word[%0d]: addr=%0d required %0d", i, wr_addr_q[i], i); else n_pass++;
        end
        test_copy_under_ready("restart", 2);
    endtask

    task automatic test_reset_mid_copy();
        int s, fc; bit ok;
        bus.dst_ready = 1'b1;
        begin_copy(s);
        for (int k = 0; k < 100 && n_wr < 8; k++) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.src_rd_en, bus.dst_wr_en, busy, copy_finished, checksum, bus.dst_wr_addr, bus.dst_wr_data} !== '0)
            $display("FAIL midreset_outputs: rd_en=%b wr_en=%b busy=%b fin=%b cs=%h waddr=%h, required all 0",
                     bus.src_rd_en, bus.dst_wr_en, busy, copy_finished, checksum, bus.dst_wr_addr);
        else n_pass++;
        clear_log();
        reset = 1'b0;
        run_until_done(0, 200, fc, ok);
        n_checks++;
        if (!ok || wr_addr_q.size() != FW) $display("FAIL midreset_count: done=%b writes=%0d required 1 %0d", ok, wr_addr_q.size(), FW);
        else n_pass++;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[i] !== i || wr_data_q[i] !== word_of(i))
                $display("FAIL midreset_word[%0d]: addr=%0d data=%h required addr=%0d data=%h", i, wr_addr_q[i], wr_data_q[i], i, word_of(i));
            else n_pass++;
        end
        n_checks++;
        if (checksum !== exp_cs(FW)) $display("FAIL midreset_checksum: %h required %h", checksum, exp_cs(FW)); else n_pass++;
        state = 3'b000;
    endtask

    task automatic test_single_word();
        bit ok = 1'b0;
        bus1.dst_ready = 1'b1;
        @(posedge clk); #1;
        wr1_addr_q.delete(); wr1_data_q.delete();
        n_checks++;
        if (cs1 !== 16'h0000 || fin1 !== 1'b0) $display("FAIL single_idle: cs=%h fin=%b required 0000 0", cs1, fin1); else n_pass++;
        state1 = COPY;
        for (int k = 0; k < 50; k++) begin @(posedge clk); #1; if (fin1) begin ok = 1'b1; break; end end
        n_checks++;
        if (!ok || wr1_addr_q.size() != 1) $display("FAIL single_count: done=%b writes=%0d required 1 1", ok, wr1_addr_q.size());
        else n_pass++;
        if (wr1_addr_q.size() > 0) begin
            n_checks++;
            if (wr1_addr_q[0] !== 0 || wr1_data_q[0] !== 16'h1000)
                $display("FAIL single_word: addr=%0d data=%h required 0 1000", wr1_addr_q[0], wr1_data_q[0]);
            else n_pass++;
        end
        n_checks++;
        if (cs1 !== exp_cs(1)) $display("FAIL single_checksum: %h required %h", cs1, exp_cs(1)); else n_pass++;
        state1 = 3'b000;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.dst_ready  = 1'b1;
        bus1.dst_ready = 1'b1;
        test_reset();
        test_free_flow();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_reset_mid_copy();
        test_single_word();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
